// File: rtl/fpalign_pkg.sv
// fpalign_pkg: shared widths and FSM state type for the iterative FP alignment shifter
package fpalign_pkg;
   localparam int FPWID = 80;
   localparam int SHWID = 7;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} fpalign_state_t;
endpackage

// File: rtl/fpalign_seq_redor80.sv
// redor80: prefix-OR, y = |b[a:0] (all bits when a >= 79)
// Ports: a (7b prefix top index), b (80b operand), y (OR of selected bits)
import fpalign_pkg::*;
module redor80 (
   input  logic [SHWID-1:0] a,
   input  logic [FPWID-1:0] b,
   output logic             y
);
   always_comb begin
      y = 1'b0;
      for (int i = 0; i < FPWID; i++) y = y | (b[i] & (SHWID'(i) <= a));
   end
endmodule

// File: rtl/fpalign_seq.sv
// fpalign_seq: iterative right-alignment shifter with sticky, at most STEP bits per cycle
// Ports: clk, rst (async high); ld/shamt/a load a job in IDLE; busy (SHIFT|DONE),
//        done (1-cycle result pulse), o = a >> shamt, sticky = OR of shifted-out bits.
// Option: FPALIGN_ZSKIP_EN ends SHIFT early once the mantissa is all zero.
import fpalign_pkg::*;
module fpalign_seq #(
   parameter int STEP = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [SHWID-1:0] shamt,
   input  logic [FPWID-1:0] a,
   output logic             busy,
   output logic             done,
   output logic [FPWID-1:0] o,
   output logic             sticky
);
   localparam logic [SHWID-1:0] STEP_W = SHWID'(STEP);
   fpalign_state_t   state_q, state_d;
   logic [FPWID-1:0] m_q, m_d;
   logic [SHWID-1:0] rem_q, rem_d, step, rem_nx;
   logic             stk_q, stk_d, red;
   assign step   = (rem_q < STEP_W) ? rem_q : STEP_W;
   assign rem_nx = rem_q - step;
   // sticky contribution: the low 'step' bits about to fall off the bottom
   redor80 u_red (.a(step - SHWID'(1)), .b(m_q), .y(red));
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      rem_d   = rem_q;
      stk_d   = stk_q;
      case (state_q)
         IDLE: if (ld) begin
            if (shamt < SHWID'(FPWID)) begin
               m_d     = a;
               rem_d   = shamt;
               stk_d   = 1'b0;
               state_d = SHIFT;
            end else begin
               // everything shifts out: result zero, sticky is |a
               m_d     = '0;
               stk_d   = |a;
               state_d = DONE;
            end
         end
         SHIFT:
`ifdef FPALIGN_ZSKIP_EN
            if (m_q == '0) begin
               rem_d   = '0;
               state_d = DONE;
            end else
`endif
            begin
               m_d   = m_q >> step;
               stk_d = (step != '0) ? (stk_q | red) : stk_q;
               rem_d = rem_nx;
               state_d = (rem_nx == '0) ? DONE : SHIFT;
            end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         rem_q   <= '0;
         stk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         rem_q   <= rem_d;
         stk_q   <= stk_d;
      end
   end
   assign busy   = state_q != IDLE;
   assign done   = state_q == DONE;
   assign o      = m_q;
   assign sticky = stk_q;
endmodule

// File: tb/tb_fpalign_seq.sv
// tb_fpalign_seq: directed self-checking bench for fpalign_seq with STEP=16
module tb_fpalign_seq;
   logic        clk = 1'b0, rst = 1'b1, ld = 1'b0;
   logic [6:0]  shamt = '0;
   logic [79:0] a = '0, o;
   logic        busy, done, sticky;
   int          nchk = 0, nerr = 0;

   fpalign_seq #(.STEP(16)) dut (
      .clk(clk), .rst(rst), .ld(ld), .shamt(shamt), .a(a),
      .busy(busy), .done(done), .o(o), .sticky(sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [79:0] av, input logic [6:0] sv,
                      input logic [79:0] eo, input logic es, input int ec, input bit noise);
      int n;
      @(negedge clk);
      a = av; shamt = sv; ld = 1'b1;
      @(posedge clk);
      #1;
      ld = noise;
      if (noise) begin
         a = '1;
         shamt = 7'd3;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      ld = 1'b0;
      chk({tag, " done_cycle"}, 80'(n), 80'(ec));
      chk({tag, " o"}, o, eo);
      chk({tag, " sticky"}, 80'(sticky), 80'(es));
      chk({tag, " busy_in_done"}, 80'(busy), 80'd1);
      @(negedge clk);
      chk({tag, " done_pulse_len"}, 80'(done), 80'd0);
      chk({tag, " idle_busy"}, 80'(busy), 80'd0);
      chk({tag, " o_hold"}, o, eo);
      chk({tag, " sticky_hold"}, 80'(sticky), 80'(es));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst o", o, 80'd0);
      chk("rst sticky", 80'(sticky), 80'd0);
      chk("rst busy", 80'(busy), 80'd0);
      chk("rst done", 80'(done), 80'd0);
      rst = 1'b0;

      run("sh5",     80'h3F,             7'd5,   80'h1,              1'b1, 2, 1'b0);
      run("sh16",    80'h1_0000,         7'd16,  80'h1,              1'b0, 2, 1'b0);
      run("sh40",    {1'b1, 79'h0},      7'd40,  80'h1 << 39,        1'b0, 4, 1'b0);
      run("fast1",   80'h1,              7'd100, 80'h0,              1'b1, 1, 1'b0);
      run("fast0",   80'h0,              7'd100, 80'h0,              1'b0, 1, 1'b0);
      run("fast80",  {80{1'b1}},         7'd80,  80'h0,              1'b1, 1, 1'b0);
      run("sh0",     80'hABCD,           7'd0,   80'hABCD,           1'b0, 2, 1'b0);
      run("sh79",    {80{1'b1}},         7'd79,  80'h1,              1'b1, 6, 1'b0);
      run("sh17",    80'h1_FFFF,         7'd17,  80'h0,              1'b1, 3, 1'b0);
      run("sh20",    80'hF_F0_0000,      7'd20,  80'hFF,             1'b0, 3, 1'b0);
      run("ignore",  {1'b1, 79'h0},      7'd40,  80'h1 << 39,        1'b0, 4, 1'b1);

      @(negedge clk);
      a = {80{1'b1}}; shamt = 7'd79; ld = 1'b1;
      @(posedge clk);
      #1;
      ld = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst o_nonzero", 80'(o != '0), 80'd1);
      rst = 1'b1;
      #1;
      chk("midrst o", o, 80'd0);
      chk("midrst sticky", 80'(sticky), 80'd0);
      chk("midrst busy", 80'(busy), 80'd0);
      chk("midrst done", 80'(done), 80'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst no_done", 80'(done), 80'd0);
      end

      run("after_rst", 80'h3F, 7'd5, 80'h1, 1'b1, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
